fsm_unit_counter: RTL and testbench

//  Parametrised, cascadable time-unit counter FSM (seconds/minutes/hours/etc.) for the clock micro-benchmarks.

---
 rtl/fsm_time_pkg.sv | 11 +
 rtl/fsm_unit_next.sv | 40 ++++
 rtl/fsm_unit_counter.sv | 107 ++++++++++
 tb/tb_fsm_unit_counter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_time_pkg.sv
// Shared state encodings for the cascadable time-unit counters.
package fsm_time_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/fsm_unit_next.sv
// Next-value and boundary detection for one time-unit digit.
// Pure combinational so multi-digit wrappers can reuse it directly.
module fsm_unit_next #(
    parameter int WIDTH   = 6,
    parameter int MAX_VAL = 59,
    parameter int WRAP    = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next_val,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cur;

    // Step the clamped current value up or down, wrapping or saturating at the ends.
    always_comb begin
        cur      = (count > MAX) ? MAX : count;
        next_val = cur;
        at_bound = 1'b0;
        if (!dir) begin
            at_bound = (cur == MAX);
            if (at_bound) begin
                next_val = (WRAP != 0) ? '0 : MAX;
            end else begin
                next_val = cur + WIDTH'(1);
            end
        end else begin
            at_bound = (cur == '0);
            if (at_bound) begin
                next_val = (WRAP != 0) ? MAX : '0;
            end else begin
                next_val = cur - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_unit_counter.sv
// Cascadable time-unit counter: load, pause, up/down stepping and a sticky alarm.
// carry_out is combinational so a chain of stages advances on the same edge.
module fsm_unit_counter #(
    parameter int WIDTH   = 6,
    parameter int MAX_VAL = 59,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick_in,
    input  logic             dir,
    input  logic             pause,
    input  logic             alarm_arm,
    input  logic [WIDTH-1:0] alarm_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             alarm,
    output logic             running
);

    import fsm_time_pkg::*;

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    state_t           state;
    logic [WIDTH-1:0] next_val;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;
    logic             step;
    logic             stepped;

    fsm_unit_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .WRAP    (WRAP)
    ) u_next (
        .count    (count),
        .dir      (dir),
        .next_val (next_val),
        .at_bound (at_bound)
    );

    assign load_clamped = (load_val > MAX) ? MAX : load_val;
    assign step         = (state == ST_RUN) && !pause && !load && tick_in;
    assign carry_out    = step && at_bound && (WRAP != 0);

    // State, count, running and alarm registers; alarm compares one cycle after a tick step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            count   <= '0;
            alarm   <= 1'b0;
            running <= 1'b0;
            stepped <= 1'b0;
        end else begin
            stepped <= step;
            alarm   <= alarm_arm && (alarm || (stepped && (count == alarm_val)));
            case (state)
                ST_INIT: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
                ST_IDLE: begin
                    if (load) begin
                        count   <= load_clamped;
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else begin
                        running <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        count   <= load_clamped;
                        running <= 1'b1;
                    end else if (pause) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else begin
                        if (tick_in) begin
                            count <= next_val;
                        end
                        running <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (load) begin
                        count   <= load_clamped;
                        running <= 1'b0;
                    end else if (!pause) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else begin
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_INIT;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_unit_counter.sv
// Scoreboard bench for fsm_unit_counter: wrapping, saturating and a chained sec->min pair.
module tb_fsm_unit_counter;

    typedef struct {
        string      name;
        logic [5:0] cnt;
        logic       cry;
        logic       run;
        logic       alm;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] load_val;
    logic       tick_in;
    logic       dir;
    logic       pause;
    logic       alarm_arm;
    logic [5:0] alarm_val;

    logic [5:0] count,     sat_count,   sec_count,   min_count;
    logic       carry_out, sat_carry,   sec_carry,   min_carry;
    logic       alarm,     sat_alarm,   sec_alarm,   min_alarm;
    logic       running,   sat_running, sec_running, min_running;

    exp_t sb[$];
    exp_t obs[$];
    int   checks;
    int   errors;

    fsm_unit_counter #(.WIDTH(6), .MAX_VAL(59), .WRAP(1)) u_dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick_in(tick_in),
        .dir(dir), .pause(pause), .alarm_arm(alarm_arm), .alarm_val(alarm_val),
        .count(count), .carry_out(carry_out), .alarm(alarm), .running(running)
    );

    fsm_unit_counter #(.WIDTH(6), .MAX_VAL(59), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick_in(tick_in),
        .dir(dir), .pause(pause), .alarm_arm(alarm_arm), .alarm_val(alarm_val),
        .count(sat_count), .carry_out(sat_carry), .alarm(sat_alarm), .running(sat_running)
    );

    fsm_unit_counter #(.WIDTH(6), .MAX_VAL(59), .WRAP(1)) u_sec (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick_in(tick_in),
        .dir(dir), .pause(pause), .alarm_arm(alarm_arm), .alarm_val(alarm_val),
        .count(sec_count), .carry_out(sec_carry), .alarm(sec_alarm), .running(sec_running)
    );

    fsm_unit_counter #(.WIDTH(6), .MAX_VAL(59), .WRAP(1)) u_min (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick_in(sec_carry),
        .dir(dir), .pause(pause), .alarm_arm(alarm_arm), .alarm_val(alarm_val),
        .count(min_count), .carry_out(min_carry), .alarm(min_alarm), .running(min_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, push the expectation, capture carry before the edge and outputs after it.
    task automatic apply(input string nm, input int which, input logic ld, input logic [5:0] lv,
                         input logic tk, input logic d, input logic ps,
                         input logic [5:0] ec, input logic ecy, input logic er, input logic ea);
        exp_t e;
        exp_t o;
        load     = ld;
        load_val = lv;
        tick_in  = tk;
        dir      = d;
        pause    = ps;
        e.name = nm; e.cnt = ec; e.cry = ecy; e.run = er; e.alm = ea;
        sb.push_back(e);
        #2;
        o.name = nm;
        o.cry  = (which == 0) ? carry_out : (which == 1) ? sat_carry : sec_carry;
        @(posedge clk);
        #1;
        case (which)
            0:       begin o.cnt = count;     o.run = running;     o.alm = alarm;     end
            1:       begin o.cnt = sat_count; o.run = sat_running; o.alm = sat_alarm; end
            default: begin o.cnt = min_count; o.run = min_running; o.alm = min_alarm; end
        endcase
        obs.push_back(o);
        load    = 1'b0;
        tick_in = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply("rst_hold",          0, 1'b1, 6'd20, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        apply("init_ignores_load", 0, 1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        apply("idle_ignores_tick", 0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
            checks++; if (o.run !== e.run) begin errors++; $display("[TB] FAIL %s running got %b want %b", e.name, o.run, e.run); end
            checks++; if (o.alm !== e.alm) begin errors++; $display("[TB] FAIL %s alarm got %b want %b", e.name, o.alm, e.alm); end
        end
    endtask

    task automatic test_count_up();
        exp_t e, o;
        apply("up_load57", 0, 1'b1, 6'd57, 1'b0, 1'b0, 1'b0, 6'd57, 1'b0, 1'b1, 1'b0);
        apply("up_58",     0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd58, 1'b0, 1'b1, 1'b0);
        apply("up_59",     0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd59, 1'b0, 1'b1, 1'b0);
        apply("up_wrap",   0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
            checks++; if (o.run !== e.run) begin errors++; $display("[TB] FAIL %s running got %b want %b", e.name, o.run, e.run); end
        end
    endtask

    task automatic test_count_down();
        exp_t e, o;
        apply("dn_load1", 0, 1'b1, 6'd1, 1'b0, 1'b1, 1'b0, 6'd1,  1'b0, 1'b1, 1'b0);
        apply("dn_0",     0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0);
        apply("dn_wrap",  0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd59, 1'b1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
        end
    endtask

    task automatic test_saturate();
        exp_t e, o;
        apply("sat_load59", 1, 1'b1, 6'd59, 1'b0, 1'b0, 1'b0, 6'd59, 1'b0, 1'b1, 1'b0);
        apply("sat_up_hold", 1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 6'd59, 1'b0, 1'b1, 1'b0);
        apply("sat_load0",  1, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0);
        apply("sat_dn_hold", 1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
        end
    endtask

    task automatic test_load_clamp();
        exp_t e, o;
        apply("clamp_63",       0, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 6'd59, 1'b0, 1'b1, 1'b0);
        apply("load_with_tick", 0, 1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 6'd5,  1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
        end
    endtask

    task automatic test_pause();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            apply("pause_hold", 0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        end
        apply("pause_release", 0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b0, 1'b1, 1'b0);
        apply("pause_resume",  0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 6'd6, 1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
            checks++; if (o.run !== e.run) begin errors++; $display("[TB] FAIL %s running got %b want %b", e.name, o.run, e.run); end
        end
    endtask

    task automatic test_alarm();
        exp_t e, o;
        alarm_arm = 1'b1;
        alarm_val = 6'd10;
        apply("alm_load10",   0, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 1'b1, 1'b0);
        apply("alm_no_load",  0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 1'b1, 1'b0);
        apply("alm_load8",    0, 1'b1, 6'd8,  1'b0, 1'b0, 1'b0, 6'd8,  1'b0, 1'b1, 1'b0);
        apply("alm_9",        0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd9,  1'b0, 1'b1, 1'b0);
        apply("alm_10",       0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd10, 1'b0, 1'b1, 1'b0);
        apply("alm_set",      0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd10, 1'b0, 1'b1, 1'b1);
        apply("alm_sticky",   0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd11, 1'b0, 1'b1, 1'b1);
        alarm_arm = 1'b0;
        apply("alm_disarm",   0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd11, 1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.alm !== e.alm) begin errors++; $display("[TB] FAIL %s alarm got %b want %b", e.name, o.alm, e.alm); end
        end
    endtask

    task automatic test_chain();
        exp_t e, o;
        logic sc;
        logic mc;
        apply("chain_load", 2, 1'b1, 6'd59, 1'b0, 1'b0, 1'b0, 6'd59, 1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s min count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s sec carry got %b want %b", e.name, o.cry, e.cry); end
            checks++; if (o.run !== e.run) begin errors++; $display("[TB] FAIL %s min running got %b want %b", e.name, o.run, e.run); end
            checks++; if (o.alm !== e.alm) begin errors++; $display("[TB] FAIL %s min alarm got %b want %b", e.name, o.alm, e.alm); end
        end
        tick_in = 1'b1;
        dir     = 1'b0;
        #2;
        sc = sec_carry;
        mc = min_carry;
        @(posedge clk);
        #1;
        tick_in = 1'b0;
        checks++; if (sc !== 1'b1) begin errors++; $display("[TB] FAIL chain_sec_carry got %b want 1", sc); end
        checks++; if (mc !== 1'b1) begin errors++; $display("[TB] FAIL chain_min_carry got %b want 1", mc); end
        checks++; if (sec_count !== 6'd0) begin errors++; $display("[TB] FAIL chain_sec_count got %0d want 0", sec_count); end
        checks++; if (min_count !== 6'd0) begin errors++; $display("[TB] FAIL chain_min_count got %0d want 0", min_count); end
        checks++; if (sec_running !== 1'b1) begin errors++; $display("[TB] FAIL chain_sec_running got %b want 1", sec_running); end
        checks++; if (sec_alarm !== 1'b0) begin errors++; $display("[TB] FAIL chain_sec_alarm got %b want 0", sec_alarm); end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        apply("mid_load30",  0, 1'b1, 6'd30, 1'b0, 1'b0, 1'b0, 6'd30, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        apply("mid_rst",     0, 1'b1, 6'd12, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        apply("mid_init",    0, 1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0);
        apply("mid_idle_ld", 0, 1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 6'd12, 1'b0, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front();
            checks++; if (o.cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s count got %0d want %0d", e.name, o.cnt, e.cnt); end
            checks++; if (o.cry !== e.cry) begin errors++; $display("[TB] FAIL %s carry got %b want %b", e.name, o.cry, e.cry); end
            checks++; if (o.run !== e.run) begin errors++; $display("[TB] FAIL %s running got %b want %b", e.name, o.run, e.run); end
            checks++; if (o.alm !== e.alm) begin errors++; $display("[TB] FAIL %s alarm got %b want %b", e.name, o.alm, e.alm); end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        load      = 1'b0;
        load_val  = 6'd0;
        tick_in   = 1'b0;
        dir       = 1'b0;
        pause     = 1'b0;
        alarm_arm = 1'b0;
        alarm_val = 6'd0;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_clamp();
        test_pause();
        test_alarm();
        test_chain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
